rob_multi_commit: RTL

//  Parametrised reorder buffer: in-order issue, out-of-order completion from CDB_PORTS

---
 rtl/rob_multi_commit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/rob_multi_commit.sv
// Reorder buffer with in-order issue, out-of-order completion over several result
// buses, operand lookup with result-bus bypass and in-order retirement of up to two entries.
module rob_multi_commit #(
    parameter int  DEPTH     = 16,
    parameter int  CDB_PORTS = 2,
    parameter int  COMMIT_W  = 2,
    localparam int TAG_W     = $clog2(DEPTH)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_rdy,
    input  logic                        i_issue_valid,
    input  logic [5:0]                  i_issue_op,
    input  logic [4:0]                  i_issue_rd,
    input  logic [31:0]                 i_issue_pc,
    input  logic [31:0]                 i_issue_imm,
    input  logic                        i_issue_predict,
    output logic [TAG_W-1:0]            o_issue_tag,
    output logic                        o_rob_full,
    input  logic [CDB_PORTS-1:0]        i_cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0]  i_cdb_tag,
    input  logic [CDB_PORTS*32-1:0]     i_cdb_value,
    input  logic [2*TAG_W-1:0]          i_q_tag,
    output logic [1:0]                  o_q_ready,
    output logic [63:0]                 o_q_value,
    output logic [COMMIT_W-1:0]         o_commit_valid,
    output logic [COMMIT_W*5-1:0]       o_commit_rd,
    output logic [COMMIT_W*TAG_W-1:0]   o_commit_tag,
    output logic [COMMIT_W*32-1:0]      o_commit_value,
    output logic                        o_commit_store,
    output logic [TAG_W-1:0]            o_head_tag,
    output logic                        o_pred_upd,
    output logic                        o_pred_taken,
    output logic [31:0]                 o_pred_pc,
    output logic                        o_rollback,
    output logic [31:0]                 o_reset_pc
);
    localparam int         CNT_W   = TAG_W + 1;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BGEU = 6'd9;
    localparam logic [5:0] OP_SB   = 6'd16;
    localparam logic [5:0] OP_SW   = 6'd18;

    function automatic logic is_store(input logic [5:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

    logic              r_ready  [DEPTH];
    logic [5:0]        r_op     [DEPTH];
    logic [4:0]        r_rd     [DEPTH];
    logic [31:0]       r_value  [DEPTH];
    logic [31:0]       r_pc     [DEPTH];
    logic [31:0]       r_rpc    [DEPTH];
    logic              r_pred   [DEPTH];
    logic [TAG_W-1:0]  r_head, r_tail;
    logic [CNT_W-1:0]  r_count;

    logic [COMMIT_W-1:0]       r_commit_valid;
    logic [COMMIT_W*5-1:0]     r_commit_rd;
    logic [COMMIT_W*TAG_W-1:0] r_commit_tag;
    logic [COMMIT_W*32-1:0]    r_commit_value;
    logic                      r_commit_store, r_pred_upd, r_pred_taken, r_rollback;
    logic [31:0]               r_pred_pc, r_reset_pc;

    logic [TAG_W-1:0]     w_head1, w_br_idx, w_cdb_off;
    logic                 w_st0, w_br0, w_st1, w_br1, w_slot0, w_slot1;
    logic                 w_br_fire, w_mispred, w_issue;
    logic [CNT_W-1:0]     w_n_ret;
    logic [COMMIT_W-1:0]  w_commit;
    logic [TAG_W-1:0]     w_cidx [COMMIT_W];
    logic [CDB_PORTS-1:0] w_cdb_ok;
    logic [1:0]           w_q_ready;
    logic [63:0]          w_q_value;

    // Issue handshake: an entry is accepted on an i_rdy cycle with i_issue_valid=1 and
    // o_rob_full=0; a request made while full is dropped, not held, so issue must retry.
    assign o_issue_tag = r_tail;
    assign o_rob_full  = r_count >= CNT_W'(DEPTH - 1);
    assign o_head_tag  = r_head;
    assign w_issue     = i_rdy && i_issue_valid && !o_rob_full;

    always_comb begin
        w_head1   = r_head + TAG_W'(1);
        w_st0     = is_store(r_op[r_head]);
        w_br0     = is_branch(r_op[r_head]);
        w_st1     = is_store(r_op[w_head1]);
        w_br1     = is_branch(r_op[w_head1]);
        w_slot0   = (r_count != '0) && r_ready[r_head];
        w_slot1   = (COMMIT_W == 2) && w_slot0 && (r_count >= CNT_W'(2)) && r_ready[w_head1]
                    && !w_st0 && !w_br0 && !w_st1;
        w_n_ret   = CNT_W'(w_slot0) + CNT_W'(w_slot1);
        w_br_fire = (w_slot0 && w_br0) || (w_slot1 && w_br1);
        w_br_idx  = (w_slot0 && w_br0) ? r_head : w_head1;
        w_mispred = w_br_fire && (r_pred[w_br_idx] != r_value[w_br_idx][0]);
        for (int s = 0; s < COMMIT_W; s++) begin
            w_commit[s] = (s == 0) ? w_slot0 : w_slot1;
            w_cidx[s]   = r_head + TAG_W'(s);
        end
        // A result only lands on a live entry that is not leaving this cycle.
        w_cdb_off = '0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            w_cdb_off   = i_cdb_tag[p*TAG_W +: TAG_W] - r_head;
            w_cdb_ok[p] = i_cdb_valid[p] && ({1'b0, w_cdb_off} >= w_n_ret)
                          && ({1'b0, w_cdb_off} < r_count);
        end
    end

    always_comb begin
        w_q_ready = '0;
        w_q_value = '0;
        for (int j = 0; j < 2; j++) begin
            w_q_ready[j]         = r_ready[i_q_tag[j*TAG_W +: TAG_W]];
            w_q_value[j*32 +: 32] = r_value[i_q_tag[j*TAG_W +: TAG_W]];
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (i_cdb_valid[p] && (i_cdb_tag[p*TAG_W +: TAG_W] == i_q_tag[j*TAG_W +: TAG_W])) begin
                    w_q_ready[j]          = 1'b1;
                    w_q_value[j*32 +: 32] = i_cdb_value[p*32 +: 32];
                end
            end
        end
    end

    assign o_q_ready = w_q_ready;
    assign o_q_value = w_q_value;

    always_ff @(posedge i_clk) begin
        if (i_rst || (i_rdy && r_rollback)) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= '0;
            r_commit_rd    <= '0;
            r_commit_tag   <= '0;
            r_commit_value <= '0;
            r_commit_store <= 1'b0;
            r_pred_upd     <= 1'b0;
            r_rollback     <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                r_ready[k] <= 1'b0;
                r_value[k] <= '0;
            end
            if (i_rst) begin
                r_pred_taken <= 1'b0;
                r_pred_pc    <= '0;
                r_reset_pc   <= '0;
            end
        end else if (i_rdy) begin
            for (int s = 0; s < COMMIT_W; s++) begin
                r_commit_valid[s]          <= w_commit[s];
                r_commit_rd[s*5 +: 5]      <= w_commit[s] ? r_rd[w_cidx[s]] : 5'd0;
                r_commit_tag[s*TAG_W +: TAG_W] <= w_commit[s] ? w_cidx[s] : '0;
                r_commit_value[s*32 +: 32] <= w_commit[s] ? r_value[w_cidx[s]] : 32'd0;
            end
            r_commit_store <= w_slot0 && w_st0;
            r_pred_upd     <= w_br_fire;
            r_rollback     <= w_mispred;
            if (w_br_fire) begin
                r_pred_taken <= r_value[w_br_idx][0];
                r_pred_pc    <= r_pc[w_br_idx];
            end
            if (w_mispred) r_reset_pc <= r_rpc[w_br_idx];
            if (w_slot0) r_ready[r_head]  <= 1'b0;
            if (w_slot1) r_ready[w_head1] <= 1'b0;
            // Later ports are written last, so the highest port index wins a tag clash.
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (w_cdb_ok[p]) begin
                    r_ready[i_cdb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
                    r_value[i_cdb_tag[p*TAG_W +: TAG_W]] <= i_cdb_value[p*32 +: 32];
                end
            end
            if (w_issue) begin
                r_op[r_tail]    <= i_issue_op;
                r_rd[r_tail]    <= i_issue_rd;
                r_pc[r_tail]    <= i_issue_pc;
                r_pred[r_tail]  <= i_issue_predict;
                r_rpc[r_tail]   <= i_issue_pc + (i_issue_predict ? 32'd4 : i_issue_imm);
                r_value[r_tail] <= '0;
                r_ready[r_tail] <= !is_branch(i_issue_op) && (i_issue_rd == 5'd0);
                r_tail          <= r_tail + TAG_W'(1);
            end
            r_head  <= r_head + w_n_ret[TAG_W-1:0];
            r_count <= r_count + CNT_W'(w_issue) - w_n_ret;
        end
    end

    assign o_commit_valid = r_commit_valid;
    assign o_commit_rd    = r_commit_rd;
    assign o_commit_tag   = r_commit_tag;
    assign o_commit_value = r_commit_value;
    assign o_commit_store = r_commit_store;
    assign o_pred_upd     = r_pred_upd;
    assign o_pred_taken   = r_pred_taken;
    assign o_pred_pc      = r_pred_pc;
    assign o_rollback     = r_rollback;
    assign o_reset_pc     = r_reset_pc;
endmodule
